unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch port and its data (memory-access) port. Sits between the 5-stage core and the memory model/bus. Each side sees a request/ready handshake; on the memory side the block issues one transaction at a time. Data requests take priority, and a bounded starvation guard keeps fetch progressing.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
DATA_WIDTH, 32, data bus width
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced through (1..15)
TIMEOUT_CYCLES, 255, BUSY cycles before abort; used only with the optional feature

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous reset, active low
i_inst_rd_en  in  1  fetch request, level, held until o_instr_ready
i_inst_addr  in  ADDR_WIDTH  fetch address
o_instr_ready  out  1  one-cycle pulse, fetch complete, o_instr_data valid
o_instr_data  out  DATA_WIDTH  fetched word, registered, held until next fetch completes
i_data_rd_en_ma  in  1  data read request, level
i_data_wr_en_ma  in  1  data write request, level
i_data_addr  in  ADDR_WIDTH  data address
i_data_wr  in  DATA_WIDTH  write data
i_data_rd_en_ctrl  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
o_data_ready  out  1  one-cycle pulse, data access complete
o_data_rd  out  DATA_WIDTH  read data, registered, held; unchanged by writes
o_mem_req  out  1  memory request, held until i_mem_ack
o_mem_we  out  1  1 = write
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_wdata  out  DATA_WIDTH  memory write data
o_mem_size  out  2  access size, same encoding as i_data_rd_en_ctrl
i_mem_ack  in  1  memory completion, single cycle; i_mem_rdata valid in that cycle
i_mem_rdata  in  DATA_WIDTH  memory read data
o_timeout_err  out  1  one-cycle pulse on aborted transaction (tied 0 without the optional feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. Starve counter 0. Entering reset mid-transaction drops o_mem_req immediately; the memory discards any in-flight access.
- FSM has three states: IDLE, BUSY and RESP.
- IDLE: if any request is pending, grant, latch owner, address, we, wdata and size into registers, then go to BUSY. With no request, stay in IDLE.
- BUSY: o_mem_req=1 with the latched fields stable. On i_mem_ack, capture i_mem_rdata (reads only) into the owner's data register and go to RESP. o_mem_req deasserts in the same cycle it is acked, i.e. it is low from the next cycle.
- RESP: pulse the owner's ready for exactly one cycle, then go to IDLE. The request is re-sampled in IDLE, so a still-asserted request at the same address is a new transaction.
- Latency: request in IDLE at cycle N, o_mem_req at N+1, earliest ack at N+1, ready at N+2. Peak throughput is one transaction per 3 cycles.
- Grant rule: data beats fetch unless starve_cnt == STARVE_LIMIT. starve_cnt increments on a data grant while i_inst_rd_en=1 and saturates at STARVE_LIMIT. It clears on a fetch grant, and in any IDLE cycle with i_inst_rd_en=0.
- Data rd and wr both asserted is illegal; write wins.
- Fetch is always word size (o_mem_size=10), o_mem_we=0, o_mem_addr = {i_inst_addr[ADDR_WIDTH-1:2],2'b00}. The data address passes through unaligned. Memory handles lane placement.
- Request inputs that change while BUSY are ignored; the latched copy is used.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined: a counter runs in BUSY. If no ack arrives after TIMEOUT_CYCLES cycles, drop o_mem_req, load 0 as read data (reads only), go to RESP, and pulse o_timeout_err together with the owner's ready. An ack arriving on the same cycle as the timeout wins, with normal completion and no error.
- Undefined: BUSY waits indefinitely and o_timeout_err is constant 0.

Test Plan:
1. Fetch only: i_inst_addr=0x0000_0106, ack 1 cycle after req, rdata=0x0013_0093. Required: o_mem_addr=0x104, size=10, we=0; o_instr_ready pulses at N+2; o_instr_data=0x0013_0093.
2. Simultaneous fetch and data read at 0x200, word size, rdata=0xDEAD_BEEF. Required: data granted first; o_data_rd=0xDEAD_BEEF; fetch is issued next; o_instr_data is unchanged until its own ack.
3. Starvation, STARVE_LIMIT=4: fetch is held and data requests are continuous. Required: exactly 4 data grants, then 1 fetch grant, then the data grants resume.
4. Write of byte 0xA5 to 0x301 with ack delayed 5 cycles. Required: o_mem_we=1, size=00, addr=0x301; req is held 5 cycles; o_data_ready pulses once; o_data_rd is unchanged.
5. rst_n low for 1 cycle during BUSY. Required: o_mem_req=0 immediately and state IDLE; a pending request is re-issued cleanly after reset release with no ready pulse from the aborted transaction.
6. With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, a data read that is never acked. Required: req drops after 8 cycles; o_timeout_err and o_data_ready pulse together; o_data_rd=0.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port unified memory between the core's instruction-fetch
// port and its data (memory-access) port. One memory transaction is in flight
// at a time. Data requests win arbitration, except that after STARVE_LIMIT
// consecutive data grants with a fetch waiting, the fetch is forced through.
//
// Optional feature (compile-time macro): MEM_ARB_TIMEOUT_EN
//   Defined   : a BUSY transaction with no ack after TIMEOUT_CYCLES cycles is
//               aborted; read data of 0 is returned and o_timeout_err pulses
//               together with the owner's ready.
//   Undefined : BUSY waits for the ack indefinitely, o_timeout_err is 0.
//
// Handshakes:
//   Requests (i_inst_rd_en, i_data_rd_en_ma / i_data_wr_en_ma) are levels held
//   by the core until the matching one-cycle ready pulse (o_instr_ready /
//   o_data_ready). The memory side holds o_mem_req with stable fields until a
//   single-cycle i_mem_ack, which also qualifies i_mem_rdata.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   i_inst_*             fetch request / address
//   o_instr_ready/_data  fetch completion pulse / registered fetched word
//   i_data_*             data read/write request, address, write data, size
//   o_data_ready/_rd     data completion pulse / registered read data
//   o_mem_*, i_mem_*     memory request side
//   o_timeout_err        abort pulse (optional feature)
//   o_dbg_state          current FSM state (0 IDLE, 1 BUSY, 2 RESP)
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_inst_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_inst_addr,
    output logic                  o_instr_ready,
    output logic [DATA_WIDTH-1:0] o_instr_data,
    input  logic                  i_data_rd_en_ma,
    input  logic                  i_data_wr_en_ma,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic [DATA_WIDTH-1:0] i_data_wr,
    input  logic [1:0]            i_data_rd_en_ctrl,
    output logic                  o_data_ready,
    output logic [DATA_WIDTH-1:0] o_data_rd,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [1:0]            o_mem_size,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_timeout_err,
    output logic [1:0]            o_dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [3:0]            starve_cnt;
    logic                  owner_data;   // 1: data port owns the transaction
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [1:0]            lat_size;
    logic [DATA_WIDTH-1:0] instr_data_q;
    logic [DATA_WIDTH-1:0] data_rd_q;
    logic                  timeout_q;

    logic                  data_req;
    logic                  starved;
    logic                  grant_fetch;
    logic                  grant_data;
    logic [1:0]            data_size;
    logic                  timeout_hit;

    assign data_req    = i_data_rd_en_ma | i_data_wr_en_ma;
    assign starved     = (starve_cnt == 4'(STARVE_LIMIT));
    assign grant_fetch = i_inst_rd_en && (!data_req || starved);
    assign grant_data  = data_req && !grant_fetch;
    // Size code 11 is presented to memory as a plain word access.
    assign data_size   = (i_data_rd_en_ctrl == 2'b11) ? 2'b10 : i_data_rd_en_ctrl;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt;

    // tmo_cnt holds the number of BUSY cycles already spent without an ack,
    // so the request is high for exactly TIMEOUT_CYCLES cycles before abort.
    // A coincident ack takes precedence in the FSM below.
    assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            owner_data   <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= 2'b00;
            instr_data_q <= '0;
            data_rd_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (!i_inst_rd_en || grant_fetch) begin
                        starve_cnt <= '0;
                    end else if (grant_data && !starved) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                    if (grant_fetch || grant_data) begin
                        owner_data <= grant_data;
                        if (grant_data) begin
                            // Write wins when both read and write are raised.
                            lat_we    <= i_data_wr_en_ma;
                            lat_addr  <= i_data_addr;
                            lat_wdata <= i_data_wr;
                            lat_size  <= data_size;
                        end else begin
                            lat_we    <= 1'b0;
                            lat_addr  <= {i_inst_addr[ADDR_WIDTH-1:2], 2'b00};
                            lat_wdata <= '0;
                            lat_size  <= 2'b10;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_mem_ack) begin
                        if (!owner_data) begin
                            instr_data_q <= i_mem_rdata;
                        end else if (!lat_we) begin
                            data_rd_q <= i_mem_rdata;
                        end
                        state <= RESP;
                    end else if (timeout_hit) begin
                        if (!owner_data) begin
                            instr_data_q <= '0;
                        end else if (!lat_we) begin
                            data_rd_q <= '0;
                        end
                        timeout_q <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_req     = (state == BUSY);
    assign o_mem_we      = lat_we;
    assign o_mem_addr    = lat_addr;
    assign o_mem_wdata   = lat_wdata;
    assign o_mem_size    = lat_size;
    assign o_instr_ready = (state == RESP) && !owner_data;
    assign o_data_ready  = (state == RESP) && owner_data;
    assign o_instr_data  = instr_data_q;
    assign o_data_rd     = data_rd_q;
    assign o_timeout_err = (state == RESP) && timeout_q;
    assign o_dbg_state   = state;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Directed bench for unified_mem_arbiter. A table of single-transaction
// vectors checks address/size/we formation, handshake latency and data
// registers; hand-written sequences cover arbitration priority, starvation,
// reset mid-transaction and (with MEM_ARB_TIMEOUT_EN) the timeout abort.
// A small memory responder acks after a programmable number of req cycles.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          i_inst_rd_en;
    logic [AW-1:0] i_inst_addr;
    logic          o_instr_ready;
    logic [DW-1:0] o_instr_data;
    logic          i_data_rd_en_ma;
    logic          i_data_wr_en_ma;
    logic [AW-1:0] i_data_addr;
    logic [DW-1:0] i_data_wr;
    logic [1:0]    i_data_rd_en_ctrl;
    logic          o_data_ready;
    logic [DW-1:0] o_data_rd;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [1:0]    o_mem_size;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;
    logic          o_timeout_err;
    logic [1:0]    o_dbg_state;

    unified_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_inst_rd_en(i_inst_rd_en), .i_inst_addr(i_inst_addr),
        .o_instr_ready(o_instr_ready), .o_instr_data(o_instr_data),
        .i_data_rd_en_ma(i_data_rd_en_ma), .i_data_wr_en_ma(i_data_wr_en_ma),
        .i_data_addr(i_data_addr), .i_data_wr(i_data_wr),
        .i_data_rd_en_ctrl(i_data_rd_en_ctrl),
        .o_data_ready(o_data_ready), .o_data_rd(o_data_rd),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_timeout_err(o_timeout_err), .o_dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0] exp_instr;
    logic [DW-1:0] exp_drd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- memory responder ----------------
    // ack_lat = number of cycles o_mem_req is high including the ack cycle;
    // 0 means never ack.
    int            ack_lat;
    logic [DW-1:0] mem_rdata;
    int            busy_cyc;

    initial begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        busy_cyc    = 0;
        forever begin
            @(negedge clk);
            if (o_mem_req === 1'b1) begin
                busy_cyc++;
                if (ack_lat != 0 && busy_cyc == ack_lat) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mem_rdata;
                end else begin
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = '0;
                end
            end else begin
                busy_cyc  = 0;
                i_mem_ack = 1'b0;
            end
        end
    end

    // ready pulse monitor
    int n_iready = 0;
    int n_dready = 0;
    always @(negedge clk) begin
        if (o_instr_ready === 1'b1) n_iready++;
        if (o_data_ready === 1'b1) n_dready++;
    end

    // ---------------- driver tasks ----------------
    task automatic drop_reqs();
        i_inst_rd_en    = 1'b0;
        i_data_rd_en_ma = 1'b0;
        i_data_wr_en_ma = 1'b0;
    endtask

    typedef struct {
        logic        inst_en;
        logic [31:0] inst_addr;
        logic        rd;
        logic        wr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [1:0]  exp_size;
        logic        exp_is_data;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        @(negedge clk);
        ack_lat           = v.lat;
        mem_rdata         = v.rdata;
        i_inst_rd_en      = v.inst_en;
        i_inst_addr       = v.inst_addr;
        i_data_rd_en_ma   = v.rd;
        i_data_wr_en_ma   = v.wr;
        i_data_addr       = v.daddr;
        i_data_wr         = v.wdata;
        i_data_rd_en_ctrl = v.size;
        @(negedge clk);
        chk($sformatf("v%0d_req", idx), 32'(o_mem_req), 32'd1);
        chk($sformatf("v%0d_addr", idx), o_mem_addr, v.exp_addr);
        chk($sformatf("v%0d_we", idx), 32'(o_mem_we), 32'(v.exp_we));
        chk($sformatf("v%0d_size", idx), 32'(o_mem_size), 32'(v.exp_size));
        if (v.exp_we) chk($sformatf("v%0d_wdata", idx), o_mem_wdata, v.wdata);
        cyc = 0;
        while (o_mem_req === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_req_cycles", idx), 32'(cyc), 32'(v.lat));
        if (v.exp_is_data) begin
            if (!v.exp_we) exp_drd = v.rdata;
        end else begin
            exp_instr = v.rdata;
        end
        chk($sformatf("v%0d_instr_ready", idx), 32'(o_instr_ready), 32'(!v.exp_is_data));
        chk($sformatf("v%0d_data_ready", idx), 32'(o_data_ready), 32'(v.exp_is_data));
        chk($sformatf("v%0d_instr_data", idx), o_instr_data, exp_instr);
        chk($sformatf("v%0d_data_rd", idx), o_data_rd, exp_drd);
        chk($sformatf("v%0d_timeout_err", idx), 32'(o_timeout_err), 32'd0);
        drop_reqs();
        @(negedge clk);
        chk($sformatf("v%0d_ready_pulse_end", idx), 32'({o_instr_ready, o_data_ready}), 32'd0);
        chk($sformatf("v%0d_state_idle", idx), 32'(o_dbg_state), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] got_addr[7];
    logic [31:0] exp_grant[7];

    initial begin
        int cyc;
        int base_i;
        int base_d;

        rst_n             = 1'b0;
        ack_lat           = 1;
        mem_rdata         = '0;
        i_inst_addr       = '0;
        i_data_addr       = '0;
        i_data_wr         = '0;
        i_data_rd_en_ctrl = 2'b00;
        drop_reqs();
        exp_instr = '0;
        exp_drd   = '0;

        //            inst addr          rd wr daddr         wdata         sz   lat rdata          exp_addr      we sz    data
        vecs[0] = '{1'b1, 32'h0000_0106, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1, 32'h0013_0093, 32'h0000_0104, 1'b0, 2'b10, 1'b0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 2'b10, 1, 32'hDEAD_BEEF, 32'h0000_0200, 1'b0, 2'b10, 1'b1};
        vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0301, 32'h0000_00A5, 2'b00, 5, 32'h1234_5678, 32'h0000_0301, 1'b1, 2'b00, 1'b1};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 2'b01, 2, 32'h0000_CAFE, 32'h0000_0102, 1'b0, 2'b01, 1'b1};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0007, 32'h0, 2'b11, 3, 32'h1111_2222, 32'h0000_0007, 1'b0, 2'b10, 1'b1};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 2'b10, 1, 32'h7777_7777, 32'h0000_0040, 1'b1, 2'b10, 1'b1};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 4, 32'h55AA_55AA, 32'hFFFF_FFFC, 1'b0, 2'b10, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_mem_fields", {o_mem_addr[29:0], o_mem_we, 1'b0} | o_mem_wdata | 32'(o_mem_size), 32'd0);
        chk("rst_readies", 32'({o_instr_ready, o_data_ready, o_timeout_err}), 32'd0);
        chk("rst_instr_data", o_instr_data, 32'd0);
        chk("rst_data_rd", o_data_rd, 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 32'(o_mem_req), 32'd0);

        // table-driven single transactions
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // simultaneous fetch and data read: data first, fetch next
        @(negedge clk);
        ack_lat = 1; mem_rdata = 32'hDEAD_BEEF;
        i_inst_rd_en = 1'b1; i_inst_addr = 32'h0000_0080;
        i_data_rd_en_ma = 1'b1; i_data_addr = 32'h0000_0200; i_data_rd_en_ctrl = 2'b10;
        @(negedge clk);
        chk("prio_first_addr", o_mem_addr, 32'h0000_0200);
        @(negedge clk);
        exp_drd = 32'hDEAD_BEEF;
        chk("prio_data_ready", 32'({o_instr_ready, o_data_ready}), 32'b01);
        chk("prio_data_rd", o_data_rd, exp_drd);
        chk("prio_instr_held", o_instr_data, exp_instr);
        i_data_rd_en_ma = 1'b0;
        mem_rdata = 32'h600D_F00D;
        @(negedge clk);
        chk("prio_gap_instr_held", o_instr_data, exp_instr);
        @(negedge clk);
        chk("prio_second_req", 32'(o_mem_req), 32'd1);
        chk("prio_second_addr", o_mem_addr, 32'h0000_0080);
        @(negedge clk);
        exp_instr = 32'h600D_F00D;
        chk("prio_instr_ready", 32'({o_instr_ready, o_data_ready}), 32'b10);
        chk("prio_instr_data", o_instr_data, exp_instr);
        drop_reqs();
        repeat (2) @(negedge clk);

        // starvation: fetch held, data continuous -> 4 data, 1 fetch, data resumes
        ack_lat = 1; mem_rdata = 32'h0BAD_C0DE;
        i_inst_rd_en = 1'b1; i_inst_addr = 32'h0000_1000;
        i_data_rd_en_ma = 1'b1; i_data_addr = 32'h0000_2000; i_data_rd_en_ctrl = 2'b10;
        exp_grant[0] = 32'h2000; exp_grant[1] = 32'h2000; exp_grant[2] = 32'h2000;
        exp_grant[3] = 32'h2000; exp_grant[4] = 32'h1000; exp_grant[5] = 32'h2000;
        exp_grant[6] = 32'h2000;
        for (int g = 0; g < 7; g++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (o_mem_req !== 1'b1 && cyc < 20);
            got_addr[g] = o_mem_addr;
            while (o_mem_req === 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
        end
        drop_reqs();
        for (int g = 0; g < 7; g++) chk($sformatf("starve_grant%0d", g), got_addr[g], exp_grant[g]);
        exp_instr = 32'h0BAD_C0DE;
        exp_drd   = 32'h0BAD_C0DE;
        repeat (2) @(negedge clk);
        chk("starve_instr_data", o_instr_data, exp_instr);
        chk("starve_data_rd", o_data_rd, exp_drd);

        // reset during BUSY
        ack_lat = 0; mem_rdata = 32'h1212_1212;
        i_data_rd_en_ma = 1'b1; i_data_addr = 32'h0000_0500; i_data_rd_en_ctrl = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("rstbusy_req_before", 32'(o_mem_req), 32'd1);
        base_i = n_iready;
        base_d = n_dready;
        rst_n = 1'b0;
        #1;
        exp_drd = '0; exp_instr = '0;
        chk("rstbusy_req_dropped", 32'(o_mem_req), 32'd0);
        chk("rstbusy_state", 32'(o_dbg_state), 32'd0);
        chk("rstbusy_data_rd", o_data_rd, exp_drd);
        chk("rstbusy_instr_data", o_instr_data, exp_instr);
        @(negedge clk);
        rst_n = 1'b1;
        ack_lat = 2;
        @(negedge clk);
        chk("rstbusy_reissue_req", 32'(o_mem_req), 32'd1);
        chk("rstbusy_reissue_addr", o_mem_addr, 32'h0000_0500);
        cyc = 0;
        while (o_mem_req === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk("rstbusy_req_cycles", 32'(cyc), 32'd2);
        exp_drd = 32'h1212_1212;
        chk("rstbusy_data_ready", 32'(o_data_ready), 32'd1);
        chk("rstbusy_data_rd_new", o_data_rd, exp_drd);
        drop_reqs();
        @(negedge clk);
        #1;
        chk("rstbusy_dready_count", 32'(n_dready - base_d), 32'd1);
        chk("rstbusy_iready_count", 32'(n_iready - base_i), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // never-acked data read aborts after 8 req cycles
        @(negedge clk);
        ack_lat = 0;
        i_data_rd_en_ma = 1'b1; i_data_addr = 32'h0000_0600; i_data_rd_en_ctrl = 2'b10;
        @(negedge clk);
        cyc = 0;
        while (o_mem_req === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", 32'(cyc), 32'd8);
        exp_drd = '0;
        chk("tmo_err_and_ready", 32'({o_timeout_err, o_data_ready}), 32'b11);
        chk("tmo_data_rd", o_data_rd, exp_drd);
        drop_reqs();
        @(negedge clk);
        chk("tmo_err_pulse_end", 32'(o_timeout_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
